// File: rtl/dff_ram.sv
// dff_ram: flip-flop single-port RAM, 32-bit words, byte writes, registered read-before-write output
module dff_ram #(
    parameter  int COLS = 1,
    localparam int AW   = 8 + $clog2(COLS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] a_i,
    input  logic [31:0]   di_i,
    output logic [31:0]   do_o
);
    logic [31:0] mem_q [256*COLS];
    logic [31:0] do_q;
    logic [31:0] do_d;
    // next read data: the addressed word before this edge's write, or hold when idle
    always_comb do_d = en_i ? mem_q[a_i] : do_q;
    // byte-lane writes; storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (en_i)
            for (int k = 0; k < 4; k++)
                if (we_i[k]) mem_q[a_i][8*k +: 8] <= di_i[8*k +: 8];
    end
    // output register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) do_q <= '0;
        else        do_q <= do_d;
    end
    assign do_o = do_q;
endmodule

// File: tb/tb_dff_ram.sv
// tb_dff_ram: directed vector bench for dff_ram (COLS=1)
module tb_dff_ram;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic [3:0]  we_i = 4'h0;
    logic [7:0]  a_i = 8'h0;
    logic [31:0] di_i = 32'h0;
    logic [31:0] do_o;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [7:0]  a;
        logic [31:0] di;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    dff_ram #(.COLS(1)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .we_i(we_i),
        .a_i(a_i), .di_i(di_i), .do_o(do_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int w);
        logic [3:0] n;
        n = 4'((w / 8) % 16);
        return {8{n}};
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] exp);
        checks++;
        if (do_o !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d got=%h exp=%h", name, idx, do_o, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic [3:0] we, input logic [7:0] a, input logic [31:0] di);
        en_i = en; we_i = we; a_i = a; di_i = di;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [3:0] we, input logic [7:0] a,
                       input logic [31:0] di, input logic [31:0] exp);
        vec_t v;
        v.en = en; v.we = we; v.a = a; v.di = di; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        // word overwrite and neighbours
        add(1, 4'hF, 8'h05, 32'hDEADBEEF, 32'h00000000);
        add(1, 4'h0, 8'h05, 32'h0,        32'hDEADBEEF);
        add(1, 4'h0, 8'h04, 32'h0,        32'h00000000);
        add(1, 4'h0, 8'h06, 32'h0,        32'h00000000);
        // half-word writes
        add(1, 4'hF, 8'h20, 32'h11111111, 32'h44444444);
        add(1, 4'hC, 8'h20, 32'hABCD0000, 32'h11111111);
        add(1, 4'h0, 8'h20, 32'h0,        32'hABCD1111);
        add(1, 4'h3, 8'h20, 32'h00005678, 32'hABCD1111);
        add(1, 4'h0, 8'h20, 32'h0,        32'hABCD5678);
        // each byte lane
        add(1, 4'hF, 8'h30, 32'h22222222, 32'h66666666);
        add(1, 4'h4, 8'h30, 32'h00EE0000, 32'h22222222);
        add(1, 4'h0, 8'h30, 32'h0,        32'h22EE2222);
        add(1, 4'h1, 8'h30, 32'h000000EE, 32'h22EE2222);
        add(1, 4'h0, 8'h30, 32'h0,        32'h22EE22EE);
        add(1, 4'h2, 8'h30, 32'h0000EE00, 32'h22EE22EE);
        add(1, 4'h0, 8'h30, 32'h0,        32'h22EEEEEE);
        add(1, 4'h8, 8'h30, 32'hEE000000, 32'h22EEEEEE);
        add(1, 4'h0, 8'h30, 32'h0,        32'hEEEEEEEE);
        // sparse pattern
        add(1, 4'h5, 8'h31, 32'h11223344, 32'h66666666);
        add(1, 4'h0, 8'h31, 32'h0,        32'h66226644);
        // EN low blocks writes and holds Do; read-during-write returns old data
        add(1, 4'hF, 8'h40, 32'hCAFEF00D, 32'h88888888);
        add(1, 4'h0, 8'h40, 32'h0,        32'hCAFEF00D);
        add(0, 4'hF, 8'h40, 32'hFFFFFFFF, 32'hCAFEF00D);
        add(0, 4'h0, 8'h05, 32'h0,        32'hCAFEF00D);
        add(1, 4'h0, 8'h40, 32'h0,        32'hCAFEF00D);
        add(1, 4'hF, 8'h40, 32'h12345678, 32'hCAFEF00D);
        add(1, 4'h0, 8'h40, 32'h0,        32'h12345678);
        // top address boundary
        add(1, 4'hF, 8'hFF, 32'hA5A5A5A5, 32'hFFFFFFFF);
        add(1, 4'h0, 8'hFF, 32'h0,        32'hA5A5A5A5);
        add(1, 4'h0, 8'h00, 32'h0,        32'h00000000);
        add(1, 4'h0, 8'h08, 32'h0,        32'h11111111);

        // reset state
        #2;
        check("reset_init", 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // pattern fill and readback
        for (int w = 0; w < 256; w++) cyc(1, 4'hF, 8'(w), pat(w));
        for (int w = 0; w < 256; w++) begin
            cyc(1, 4'h0, 8'(w), 32'h0);
            check("fill", w, pat(w));
        end

        // directed vectors
        foreach (vecs[i]) begin
            cyc(vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].di);
            check("vec", i, vecs[i].exp);
        end

        // Do stays stable over idle cycles
        cyc(1, 4'h0, 8'h05, 32'h0);
        check("hold_pre", 0, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 4'hF, 8'(i), 32'h0);
            check("hold_idle", i, 32'hDEADBEEF);
        end

        // asynchronous reset mid-cycle clears Do but not memory
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_async", 0, 32'h0);
        cyc(1, 4'h0, 8'h20, 32'h0);
        check("reset_held", 0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 0, 32'h0);
        cyc(1, 4'h0, 8'h05, 32'h0);
        check("post_reset_read", 0, 32'hDEADBEEF);
        cyc(1, 4'h0, 8'h00, 32'h0);
        check("post_reset_a0", 0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
